cache_arbiter: RTL and testbench
================================

// Module: cache_arbiter
// PURPOSE
//  Shares the single cacheline adapter / physical memory port between the I-cache and D-cache miss paths.
//  Sits between both caches and the cacheline adapter in the mp4 top.
//  Grants one requester at a time through a 3-state FSM and registers the granted address/wdata.
//  Routes the memory response back to the granted cache only.
// PARAMETERS
//  LINE_WIDTH  256  cacheline width in bits (rdata/wdata)
//  ADDR_WIDTH  32   line address width
// PORTS
//  clk             in   1           system clock, rising edge
//  rst             in   1           asynchronous reset, active-low
//  i_pmem_read     in   1           I-cache line fill request
//  i_pmem_address  in   ADDR_WIDTH  I-cache line address
//  i_pmem_rdata    out  LINE_WIDTH  fill data to I-cache
//  i_pmem_resp     out  1           I-cache completion pulse
//  d_pmem_read     in   1           D-cache line fill request
//  d_pmem_write    in   1           D-cache writeback request
//  d_pmem_address  in   ADDR_WIDTH  D-cache line address
//  d_pmem_wdata    in   LINE_WIDTH  D-cache writeback data
//  d_pmem_rdata    out  LINE_WIDTH  fill data to D-cache
//  d_pmem_resp     out  1           D-cache completion pulse
//  mem_read        out  1           read request to cacheline adapter
//  mem_write       out  1           write request to cacheline adapter
//  mem_address     out  ADDR_WIDTH  registered granted address
//  mem_wdata       out  LINE_WIDTH  registered granted write data
//  mem_rdata       in   LINE_WIDTH  line data from adapter
//  mem_resp        in   1           adapter completion, 1-cycle pulse
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE.
//    mem_read, mem_write, mem_address, mem_wdata, i_pmem_resp, d_pmem_resp = 0.
//    last_grant=I. An in-flight transfer is abandoned; the adapter shares the same reset.
//  - States:
//    IDLE:   no grant. If any request is pending, capture address/op/wdata and move to SERVE_I or SERVE_D.
//    SERVE_I: hold mem_read=1 until mem_resp. Pulse i_pmem_resp in the mem_resp cycle, then go to IDLE.
//    SERVE_D: hold mem_read or mem_write (captured op) until mem_resp. Pulse d_pmem_resp, then go to IDLE.
//  - Latency: request seen in IDLE at cycle N -> mem_read/mem_write asserted at N+1.
//    Mandatory one-cycle IDLE bubble after every resp, so the earliest next grant asserts at R+2.
//  - mem_* outputs are registered at grant and constant for the whole transaction.
//  - x_pmem_rdata = mem_rdata combinationally, gated to 0 for the non-granted side.
//  - x_pmem_resp = mem_resp & (state==SERVE_x), combinational, exactly 1 cycle.
//  - mem_resp in IDLE is ignored; no resp is forwarded.
//  - Requester drops its request mid-service: the transaction still completes and the resp still pulses.
//  - d_pmem_read & d_pmem_write both high (illegal): treated as a write.
//  - Requests arriving during SERVE_x wait; the granted side's new request is evaluated only in IDLE.
//  - Only one of mem_read/mem_write is ever high.
// CONFIGURATION
//  CACHE_ARB_RR_EN undefined: fixed priority, D-cache wins when both request in IDLE.
//  CACHE_ARB_RR_EN defined: when both request in IDLE, grant the side not in last_grant.
//    last_grant updates on each grant.
//    A single pending request is always granted regardless of last_grant.
// TESTING
//  1. Reset: hold rst=0 with requests asserted -> all outputs 0, no grant.
//     Release rst -> grant at the next edge.
//  2. Lone I fill, addr 0x0000_1040: mem_read=1, mem_address=0x1040 one cycle later.
//     mem_resp with rdata=0xA5..A5 -> i_pmem_resp=1 and i_pmem_rdata=0xA5..A5 that cycle, d_pmem_resp=0.
//  3. D writeback, addr 0x8000_0020, wdata=0xDEAD..BEEF: mem_write=1 with the same values.
//     mem_read=0 throughout; d_pmem_resp pulses on mem_resp.
//  4. I and D request in the same IDLE cycle, macro off -> D served first, then bubble, then I.
//     Macro on, last_grant=D -> I served first.
//  5. d_pmem_address changed to 0x0 mid-service -> mem_address stays at the captured value.
//     Spurious mem_resp in IDLE -> no x_pmem_resp.
//  6. rst=0 mid-SERVE_D -> mem_write drops immediately, state=IDLE, no resp pulsed.

Source files
------------

// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter
//
// Shares the single cacheline adapter / physical memory port between the
// I-cache and D-cache miss paths. One requester is granted at a time. The
// granted address, operation and write data are registered at grant and held
// for the whole transaction. The adapter's response is routed back only to the
// granted cache.
//
// Optional feature macro:
//   CACHE_ARB_RR_EN  undefined : fixed priority, D-cache wins a tie in IDLE.
//                    defined   : a tie in IDLE goes to the side that was not
//                                granted last; a lone request always wins.
//
// Parameters:
//   LINE_WIDTH  cacheline width in bits (rdata/wdata)
//   ADDR_WIDTH  line address width
//
// Ports:
//   clk              in   system clock, rising edge
//   rst              in   asynchronous reset, active-low
//   i_pmem_read      in   I-cache line fill request
//   i_pmem_address   in   I-cache line address
//   i_pmem_rdata     out  fill data to I-cache (0 unless I is granted)
//   i_pmem_resp      out  I-cache completion pulse
//   d_pmem_read      in   D-cache line fill request
//   d_pmem_write     in   D-cache writeback request
//   d_pmem_address   in   D-cache line address
//   d_pmem_wdata     in   D-cache writeback data
//   d_pmem_rdata     out  fill data to D-cache (0 unless D is granted)
//   d_pmem_resp      out  D-cache completion pulse
//   mem_read         out  read request to cacheline adapter (registered)
//   mem_write        out  write request to cacheline adapter (registered)
//   mem_address      out  registered granted address
//   mem_wdata        out  registered granted write data
//   mem_rdata        in   line data from adapter
//   mem_resp         in   adapter completion, 1-cycle pulse
//   dbg_state        out  current FSM state (0 IDLE, 1 SERVE_I, 2 SERVE_D)
//   dbg_last_grant   out  side granted most recently (0 I, 1 D)
//
// Handshake: a cache raises read/write as a level and holds it until it sees
// its x_pmem_resp pulse; the arbiter samples requests only in IDLE. Towards the
// adapter, mem_read/mem_write are held high until the single-cycle mem_resp,
// which ends the transaction. Every resp is followed by one IDLE cycle before
// the next grant can be made.
// -----------------------------------------------------------------------------
module cache_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,

    output logic [1:0]            dbg_state,
    output logic                  dbg_last_grant
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t state;
    logic   last_grant;

    logic   i_req;
    logic   d_req;
    logic   pick_d;
    logic   serve_i;
    logic   serve_d;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // pick_d is only ever high when d_req is high, so "else if (i_req)"
    // below covers every remaining pending case.
`ifdef CACHE_ARB_RR_EN
    assign pick_d = (i_req && d_req) ? (last_grant == GRANT_I) : d_req;
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_grant  <= GRANT_I;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state       <= SERVE_D;
                        last_grant  <= GRANT_D;
                        // Read and write together is illegal; the write wins
                        // so a dirty line is never lost.
                        mem_write   <= d_pmem_write;
                        mem_read    <= d_pmem_read & ~d_pmem_write;
                        mem_address <= d_pmem_address;
                        mem_wdata   <= d_pmem_wdata;
                    end else if (i_req) begin
                        state       <= SERVE_I;
                        last_grant  <= GRANT_I;
                        mem_read    <= 1'b1;
                        mem_write   <= 1'b0;
                        mem_address <= i_pmem_address;
                        mem_wdata   <= '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Address/wdata are left untouched so they stay stable
                    // right up to and including the resp cycle.
                    if (mem_resp) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign serve_i = (state == SERVE_I);
    assign serve_d = (state == SERVE_D);

    // A resp arriving in IDLE matches neither term and is dropped.
    assign i_pmem_resp  = mem_resp & serve_i;
    assign d_pmem_resp  = mem_resp & serve_d;
    assign i_pmem_rdata = serve_i ? mem_rdata : '0;
    assign d_pmem_rdata = serve_d ? mem_rdata : '0;

    assign dbg_state      = state;
    assign dbg_last_grant = last_grant;

endmodule

// File: tb/tb_cache_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_arbiter
//
// Self-checking bench for cache_arbiter. A transaction-level reference model
// decides, whenever the arbiter is free and something is pending, which side
// wins and what the adapter must see, and queues that transaction. Outputs are
// compared against the head of the queue every cycle. Directed sequences cover
// reset, lone I fill, D writeback, simultaneous requests, mid-service address
// change, spurious resp and reset mid-service; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;
  localparam int TW = 2 + AW + LW;   // {is_d, is_write, addr, wdata}

`ifdef CACHE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          i_pmem_read = 1'b0;
  logic [AW-1:0] i_pmem_address = '0;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read = 1'b0;
  logic          d_pmem_write = 1'b0;
  logic [AW-1:0] d_pmem_address = '0;
  logic [LW-1:0] d_pmem_wdata = '0;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;
  logic [1:0]    dbg_state;
  logic          dbg_last_grant;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp),
    .dbg_state      (dbg_state),
    .dbg_last_grant (dbg_last_grant)
  );

  // ---------------- scoreboard / model state ----------------
  logic [TW-1:0] exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  act = 1'b0;        // a transaction is in service this cycle
  bit  m_last_d = 1'b0;   // model's record of the last granted side
  bit  served_i = 1'b0;
  bit  served_d = 1'b0;
  int  svc_len = 0;
  int  resp_delay = 0;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // Arbiter free + something pending -> new transaction. A resp frees the
  // arbiter only from the following cycle, which gives the IDLE bubble.
  task automatic model_edge();
    bit req_i, req_d, pick_d, wr;
    served_i = 1'b0;
    served_d = 1'b0;
    if (!rst) begin
      act = 1'b0;
      m_last_d = 1'b0;
      exp_q.delete();
      return;
    end
    if (act) begin
      if (mem_resp) begin
        act = 1'b0;
        if (exp_q[0][TW-1]) served_d = 1'b1;
        else                served_i = 1'b1;
        void'(exp_q.pop_front());
      end else begin
        svc_len++;
      end
    end else begin
      req_i = i_pmem_read;
      req_d = d_pmem_read || d_pmem_write;
      if (req_i || req_d) begin
        if (req_i && req_d) pick_d = RR ? !m_last_d : 1'b1;
        else                pick_d = req_d;
        wr = pick_d && d_pmem_write;
        if (pick_d) exp_q.push_back({1'b1, wr, d_pmem_address, d_pmem_wdata});
        else        exp_q.push_back({1'b0, 1'b0, i_pmem_address, {LW{1'b0}}});
        m_last_d   = pick_d;
        act        = 1'b1;
        svc_len    = 0;
        resp_delay = $urandom_range(0, 4);
      end
    end
  endtask

  task automatic check_cycle();
    logic [TW-1:0] f;
    bit a_d, a_wr;
    f = '0;
    if (act) f = exp_q[0];
    a_d  = f[TW-1];
    a_wr = f[TW-2];
    chk("mem_read",  {255'd0, mem_read},  {255'd0, act && !a_wr});
    chk("mem_write", {255'd0, mem_write}, {255'd0, act && a_wr});
    if (act) begin
      chk("mem_address", {224'd0, mem_address}, {224'd0, f[LW +: AW]});
      if (a_wr) chk("mem_wdata", mem_wdata, f[LW-1:0]);
    end
    chk("i_pmem_resp", {255'd0, i_pmem_resp}, {255'd0, act && !a_d && mem_resp});
    chk("d_pmem_resp", {255'd0, d_pmem_resp}, {255'd0, act && a_d && mem_resp});
    chk("i_pmem_rdata", i_pmem_rdata, (act && !a_d) ? mem_rdata : {LW{1'b0}});
    chk("d_pmem_rdata", d_pmem_rdata, (act && a_d) ? mem_rdata : {LW{1'b0}});
  endtask

  // Called at a negedge after the caller has driven this cycle's inputs.
  task automatic step();
    #1 check_cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    act = 1'b0;
    m_last_d = 1'b0;
    exp_q.delete();
    i_pmem_read  = 1'b1;
    d_pmem_write = 1'b1;
    mem_resp     = 1'b1;
    #1;
    chk("rst_mem_read",  {255'd0, mem_read},  '0);
    chk("rst_mem_write", {255'd0, mem_write}, '0);
    chk("rst_mem_addr",  {224'd0, mem_address}, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_state",     {254'd0, dbg_state}, '0);
    chk("rst_last",      {255'd0, dbg_last_grant}, '0);
    repeat (3) step();
    mem_resp = 1'b0;
    rst = 1'b1;
  endtask

  // ---------------- random driver ----------------
  task automatic drive_random(input bit allow_new);
    bit own_i, own_d;
    own_d = act && exp_q[0][TW-1];
    own_i = act && !exp_q[0][TW-1];
    mem_rdata = rand_line();
    if (act) mem_resp = (svc_len >= resp_delay);
    else     mem_resp = ($urandom_range(0, 7) == 0);
    if (own_i) begin
      if ($urandom_range(0, 7) == 0) i_pmem_read = 1'b0;
      if ($urandom_range(0, 7) == 0) i_pmem_address = '0;
    end else if (served_i || !i_pmem_read) begin
      i_pmem_read    = allow_new && ($urandom_range(0, 2) != 0);
      i_pmem_address = $urandom();
    end
    if (own_d) begin
      if ($urandom_range(0, 7) == 0) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
      if ($urandom_range(0, 7) == 0) d_pmem_address = '0;
      if ($urandom_range(0, 7) == 0) d_pmem_wdata = rand_line();
    end else if (served_d || !(d_pmem_read || d_pmem_write)) begin
      {d_pmem_read, d_pmem_write} = 2'b00;
      if (allow_new && $urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 5))
          0:       {d_pmem_read, d_pmem_write} = 2'b11;
          1, 2:    {d_pmem_read, d_pmem_write} = 2'b01;
          default: {d_pmem_read, d_pmem_write} = 2'b10;
        endcase
      end
      d_pmem_address = $urandom();
      d_pmem_wdata   = rand_line();
    end
  endtask

  // ---------------- main sequence ----------------
  logic [LW-1:0] line_a5;
  logic [LW-1:0] line_db;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] second_addr;

  initial begin
    line_a5 = {8{32'hA5A5_A5A5}};
    line_db = {4{64'hDEAD_0000_0000_BEEF}};
    @(negedge clk);

    // Reset with requests asserted, then release: D (tie, last=I) granted next edge.
    do_reset();
    step();
    chk("t1_grant_write", {255'd0, mem_write}, {255'd0, 1'b1});
    i_pmem_read = 1'b0; d_pmem_write = 1'b0; mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    step();

    // Lone I fill.
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1040;
    step();
    chk("t2_read", {255'd0, mem_read}, {255'd0, 1'b1});
    chk("t2_addr", {224'd0, mem_address}, {224'd0, 32'h0000_1040});
    i_pmem_read = 1'b0;
    mem_resp = 1'b1; mem_rdata = line_a5;
    #1;
    chk("t2_iresp",  {255'd0, i_pmem_resp}, {255'd0, 1'b1});
    chk("t2_irdata", i_pmem_rdata, line_a5);
    chk("t2_dresp",  {255'd0, d_pmem_resp}, '0);
    step();
    mem_resp = 1'b0;
    step();

    // D writeback, with the address changed mid-service.
    d_pmem_write = 1'b1; d_pmem_address = 32'h8000_0020; d_pmem_wdata = line_db;
    step();
    chk("t3_write", {255'd0, mem_write}, {255'd0, 1'b1});
    chk("t3_read",  {255'd0, mem_read}, '0);
    chk("t3_wdata", mem_wdata, line_db);
    d_pmem_write = 1'b0; d_pmem_address = '0;
    step();
    chk("t5_addr_held", {224'd0, mem_address}, {224'd0, 32'h8000_0020});
    mem_resp = 1'b1; mem_rdata = rand_line();
    #1;
    chk("t3_dresp", {255'd0, d_pmem_resp}, {255'd0, 1'b1});
    chk("t3_iresp", {255'd0, i_pmem_resp}, '0);
    step();
    // Spurious resp during the IDLE bubble.
    #1;
    chk("t5_spur_i", {255'd0, i_pmem_resp}, '0);
    chk("t5_spur_d", {255'd0, d_pmem_resp}, '0);
    step();
    mem_resp = 1'b0;

    // Simultaneous requests; last grant was D.
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0100;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0200;
    first_addr  = RR ? 32'h0000_0100 : 32'h0000_0200;
    second_addr = RR ? 32'h0000_0200 : 32'h0000_0100;
    step();
    chk("t4_first", {224'd0, mem_address}, {224'd0, first_addr});
    if (mem_address == 32'h0000_0100) i_pmem_read = 1'b0;
    else d_pmem_read = 1'b0;
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    chk("t4_bubble", {255'd0, mem_read | mem_write}, '0);
    step();
    chk("t4_second", {224'd0, mem_address}, {224'd0, second_addr});
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    step();

    // Reset in the middle of a D writeback.
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_0044;
    step();
    chk("t6_write", {255'd0, mem_write}, {255'd0, 1'b1});
    do_reset();
    i_pmem_read = 1'b0; d_pmem_write = 1'b0;
    step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      drive_random(1'b1);
      step();
    end
    for (int c = 0; c < 30 && (act || i_pmem_read || d_pmem_read || d_pmem_write); c++) begin
      drive_random(1'b0);
      step();
    end
    chk("drain_done", {255'd0, act}, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
